// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: opcode encoding, arbiter states, datapath width.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two request ports plus the tagged response channel of the ALU arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [ALU_W-1:0] req0_a;
  logic [ALU_W-1:0] req0_b;
  alu_op_e          req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [ALU_W-1:0] req1_a;
  logic [ALU_W-1:0] req1_b;
  alu_op_e          req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [ALU_W-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow, busy
  );

endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: add/sub with carry and signed overflow, logic ops, 1-bit shifts.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  alu_op_e          Opcode,
  output logic [ALU_W-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow
);

  logic [ALU_W:0] wide_s;

  // Carry is the add carry-out, the subtract borrow, or the bit shifted out
  always_comb begin
    wide_s   = '0;
    Carry    = 1'b0;
    Overflow = 1'b0;
    case (Opcode)
      ADD: begin
        wide_s   = {1'b0, A} + {1'b0, B};
        Carry    = wide_s[ALU_W];
        Overflow = (A[ALU_W-1] == B[ALU_W-1]) && (wide_s[ALU_W-1] != A[ALU_W-1]);
      end
      SUB: begin
        wide_s   = {1'b0, A} - {1'b0, B};
        Carry    = wide_s[ALU_W];
        Overflow = (A[ALU_W-1] != B[ALU_W-1]) && (wide_s[ALU_W-1] != A[ALU_W-1]);
      end
      AND: wide_s = {1'b0, A & B};
      OR:  wide_s = {1'b0, A | B};
      XOR: wide_s = {1'b0, A ^ B};
      NOT: wide_s = {1'b0, ~A};
      SHL: begin
        wide_s = {A, 1'b0};
        Carry  = A[ALU_W-1];
      end
      SHR: begin
        wide_s = {1'b0, 1'b0, A[ALU_W-1:1]};
        Carry  = A[0];
      end
      default: wide_s = '0;
    endcase
  end

  assign Result = wide_s[ALU_W-1:0];
  assign Zero   = (wide_s[ALU_W-1:0] == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_8bit between two valid/ready requesters; one operation in flight,
// registered tagged response held until the consumer accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_EXEC = 2'(EXEC);
  localparam logic [1:0] S_RESP = 2'(RESP);

  logic [1:0]       state_r;
  logic             last_grant_r;
  logic             id_r;
  logic [ALU_W-1:0] a_r;
  logic [ALU_W-1:0] b_r;
  alu_op_e          op_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [ALU_W-1:0] rsp_result_r;
  logic             rsp_carry_r;
  logic             rsp_zero_r;
  logic             rsp_overflow_r;
  logic             busy_r;

  logic             grant_s;
  logic             any_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic [ALU_W-1:0] alu_result_s;
  logic             alu_carry_s;
  logic             alu_zero_s;
  logic             alu_overflow_s;

  // Winner among the valid ports; a contested grant alternates only when FAIR
  always_comb begin
    grant_s = 1'b0;
    any_s   = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      any_s = 1'b1;
      if (FAIR) begin
        grant_s = ~last_grant_r;
      end else begin
        grant_s = 1'b0;
      end
    end else if (bus.req0_valid) begin
      any_s   = 1'b1;
      grant_s = 1'b0;
    end else if (bus.req1_valid) begin
      any_s   = 1'b1;
      grant_s = 1'b1;
    end else begin
      any_s   = 1'b0;
      grant_s = 1'b0;
    end
  end

  // Ready only to the winner, only while idle and out of reset
  always_comb begin
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if ((state_r == S_IDLE) && !rst && any_s) begin
      ready0_s = ~grant_s;
      ready1_s = grant_s;
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  assign accept_s = ready0_s | ready1_s;

  alu_8bit u_alu (
    .A        (a_r),
    .B        (b_r),
    .Opcode   (op_r),
    .Result   (alu_result_s),
    .Carry    (alu_carry_s),
    .Zero     (alu_zero_s),
    .Overflow (alu_overflow_s)
  );

  // Control FSM, operand capture and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      last_grant_r   <= 1'b1;
      id_r           <= 1'b0;
      a_r            <= '0;
      b_r            <= '0;
      op_r           <= ADD;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= 1'b0;
      rsp_result_r   <= '0;
      rsp_carry_r    <= 1'b0;
      rsp_zero_r     <= 1'b0;
      rsp_overflow_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            a_r          <= grant_s ? bus.req1_a  : bus.req0_a;
            b_r          <= grant_s ? bus.req1_b  : bus.req0_b;
            op_r         <= grant_s ? bus.req1_op : bus.req0_op;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            busy_r       <= 1'b1;
            state_r      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result_r   <= alu_result_s;
          rsp_carry_r    <= alu_carry_s;
          rsp_zero_r     <= alu_zero_s;
          rsp_overflow_r <= alu_overflow_s;
          rsp_id_r       <= id_r;
          rsp_valid_r    <= 1'b1;
          state_r        <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready   = ready0_s;
  assign bus.req1_ready   = ready1_s;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_id       = rsp_id_r;
  assign bus.rsp_result   = rsp_result_r;
  assign bus.rsp_carry    = rsp_carry_r;
  assign bus.rsp_zero     = rsp_zero_r;
  assign bus.rsp_overflow = rsp_overflow_r;
  assign bus.busy         = busy_r;

endmodule
